// File: rtl/uart_comm_engine.sv
// rtl/uart_comm_engine.sv - UART host packet protocol engine (job load, ping/info replies, nonce reporting)
//
// Purpose: parses [LEN][00][00][TYPE][payload] packets from a byte-stream UART
// receiver, loads mining work, answers PING/GET_INFO, and reports golden
// nonces from a small FIFO back to the host through the UART transmitter.
//
// Optional feature macro: UART_COMM_CRC_EN
//   defined   -> every RX and TX packet carries 2 trailing CRC-16/CCITT bytes
//                (poly 0x1021, init 0xFFFF, MSB first), counted in LEN
//   undefined -> no CRC bytes
//
// Ports:
//   i_sys_clk      clock (UART domain)
//   i_reset_n      asynchronous active-low reset
//   i_rx_valid     1-cycle strobe, i_rx_byte valid
//   i_rx_byte      received byte
//   i_rx_error     framing error on the current byte
//   o_tx_start     1-cycle strobe, send o_tx_byte
//   o_tx_byte      byte to send
//   i_tx_busy      UART transmitter busy
//   o_work_data    last accepted job, first payload byte in the MSBs
//   o_work_valid   1-cycle pulse when o_work_data updates
//   i_nonce_in     golden nonce from the hashing cores
//   i_nonce_push   write i_nonce_in into the nonce FIFO
//   o_nonce_full   nonce FIFO full; pushes while full are dropped
//   o_rx_drop_cnt  saturating count of dropped/invalid packets
module uart_comm_engine #(
  parameter int          WORK_BYTES  = 12,
  parameter int          NONCE_BYTES = 4,
  parameter int          NONCE_DEPTH = 4,
  parameter int          RX_TIMEOUT  = 120000,
  parameter logic [63:0] SYS_INFO    = 64'hDEADBEEF13370D13
) (
  input  logic                     i_sys_clk,
  input  logic                     i_reset_n,
  input  logic                     i_rx_valid,
  input  logic [7:0]               i_rx_byte,
  input  logic                     i_rx_error,
  output logic                     o_tx_start,
  output logic [7:0]               o_tx_byte,
  input  logic                     i_tx_busy,
  output logic [WORK_BYTES*8-1:0]  o_work_data,
  output logic                     o_work_valid,
  input  logic [NONCE_BYTES*8-1:0] i_nonce_in,
  input  logic                     i_nonce_push,
  output logic                     o_nonce_full,
  output logic [7:0]               o_rx_drop_cnt
);

`ifdef UART_COMM_CRC_EN
  localparam int CRC_BYTES = 2;
`else
  localparam int CRC_BYTES = 0;
`endif

  localparam int WB        = WORK_BYTES * 8;
  localparam int NB        = NONCE_BYTES * 8;
  localparam int PW        = (NB > 64) ? NB : 64;
  localparam int AW        = $clog2(NONCE_DEPTH);
  localparam int TW        = $clog2(RX_TIMEOUT + 1);
  localparam int MIN_LEN   = 4 + CRC_BYTES;
  localparam int JOB_LEN   = 4 + WORK_BYTES + CRC_BYTES;
  localparam int INFO_LEN  = 12 + CRC_BYTES;
  localparam int NONCE_LEN = 4 + NONCE_BYTES + CRC_BYTES;

  localparam logic [7:0] TYPE_INFO    = 8'd0;
  localparam logic [7:0] TYPE_INVALID = 8'd1;
  localparam logic [7:0] TYPE_PING    = 8'd2;
  localparam logic [7:0] TYPE_PONG    = 8'd3;
  localparam logic [7:0] TYPE_JOB     = 8'd4;
  localparam logic [7:0] TYPE_ACK     = 8'd5;
  localparam logic [7:0] TYPE_NONCE   = 8'd6;

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(NONCE_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_HDR, RX_PAYLOAD, RX_DISPATCH} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  rx_state_t r_rx_state, w_rx_next;
  tx_state_t r_tx_state, w_tx_next;

  // RX packet capture
  logic [7:0]    r_rx_len;
  logic [7:0]    r_rx_cnt;      // bytes of the current packet received so far
  logic [7:0]    r_rx_type;
  logic          r_hdr_bad;     // one of the two reserved header bytes was non-zero
  logic          r_len_bad;
  logic [TW-1:0] r_idle_cnt;
  logic [WB-1:0] r_payload;

  // Reply slot, job output, drop counter
  logic          r_reply_pend;
  logic [7:0]    r_reply_type;
  logic [WB-1:0] r_work_data;
  logic          r_work_valid;
  logic [7:0]    r_drop_cnt;

  // TX packet generation
  logic [7:0]    r_tx_len;
  logic [7:0]    r_tx_type;
  logic [7:0]    r_tx_idx;
  logic [7:0]    r_tx_byte;
  logic          r_tx_start;
  logic          r_tx_is_nonce;
  logic [PW-1:0] r_tx_payload;  // left-aligned, shifted out MSB byte first

  // Nonce FIFO, pointers carry one extra wrap bit
  logic [NB-1:0] r_fifo [NONCE_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

`ifdef UART_COMM_CRC_EN
  logic [15:0]   r_rx_crc;
  logic [15:0]   r_tx_crc;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  logic          w_rx_ok, w_rx_err, w_in_pkt, w_timeout, w_accept_len, w_rx_last, w_rx_data;
  logic          w_crc_ok, w_pkt_ok, w_is_ping, w_is_info, w_is_job, w_dispatch, w_drop_inc;
  logic [7:0]    w_reply_type;
  logic          w_tx_load, w_load_reply, w_tx_fire, w_tx_last, w_tx_data, w_pop, w_push;
  logic [7:0]    w_tx_cur;
  logic [AW:0]   w_fifo_cnt;
  logic          w_fifo_empty, w_fifo_full;
  logic [NB-1:0] w_fifo_head;
  logic [PW-1:0] w_info_al, w_nonce_al;

  // ---------------------------------------------------------------- RX
  assign w_rx_ok   = i_rx_valid && !i_rx_error;
  assign w_rx_err  = i_rx_valid && i_rx_error;
  assign w_in_pkt  = (r_rx_state == RX_HDR) || (r_rx_state == RX_PAYLOAD);
  assign w_timeout = w_in_pkt && (r_idle_cnt >= TW'(RX_TIMEOUT));
  // DISPATCH lasts one cycle; a LEN byte arriving then still starts a packet
  assign w_accept_len = w_rx_ok && ((r_rx_state == RX_IDLE) || (r_rx_state == RX_DISPATCH));
  assign w_rx_last = (r_rx_cnt + 8'd1) == r_rx_len;
  // Payload bytes sit between the header and any trailing CRC
  assign w_rx_data = (r_rx_cnt >= 8'd4) && (r_rx_cnt < (r_rx_len - 8'(CRC_BYTES)));

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_rx_state <= RX_IDLE;
    else            r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE, RX_DISPATCH: begin
        w_rx_next = RX_IDLE;
        if (w_accept_len) begin
          // A LEN below 4 is already a complete (bad) packet
          if (i_rx_byte < 8'd4) w_rx_next = RX_DISPATCH;
          else                  w_rx_next = RX_HDR;
        end
      end
      RX_HDR: begin
        if (w_rx_err || w_timeout) w_rx_next = RX_IDLE;
        else if (w_rx_ok && (r_rx_cnt == 8'd3)) w_rx_next = w_rx_last ? RX_DISPATCH : RX_PAYLOAD;
      end
      RX_PAYLOAD: begin
        if (w_rx_err || w_timeout) w_rx_next = RX_IDLE;
        else if (w_rx_ok && w_rx_last) w_rx_next = RX_DISPATCH;
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_len   <= '0;
      r_rx_cnt   <= '0;
      r_rx_type  <= '0;
      r_hdr_bad  <= 1'b0;
      r_len_bad  <= 1'b0;
      r_idle_cnt <= '0;
      r_payload  <= '0;
`ifdef UART_COMM_CRC_EN
      r_rx_crc   <= 16'hFFFF;
`endif
    end else begin
      if (w_in_pkt && !i_rx_valid) r_idle_cnt <= r_idle_cnt + TW'(1);
      else                         r_idle_cnt <= '0;

      if (w_accept_len) begin
        r_rx_len  <= i_rx_byte;
        r_rx_cnt  <= 8'd1;
        r_hdr_bad <= 1'b0;
        r_len_bad <= (i_rx_byte < 8'(MIN_LEN)) || (i_rx_byte > 8'(JOB_LEN));
`ifdef UART_COMM_CRC_EN
        r_rx_crc  <= crc16_step(16'hFFFF, i_rx_byte);
`endif
      end else if (w_in_pkt && w_rx_ok) begin
        r_rx_cnt <= r_rx_cnt + 8'd1;
        if ((r_rx_cnt == 8'd1) || (r_rx_cnt == 8'd2))
          r_hdr_bad <= r_hdr_bad | (i_rx_byte != 8'h00);
        if (r_rx_cnt == 8'd3) r_rx_type <= i_rx_byte;
        if (w_rx_data) r_payload <= {r_payload[WB-9:0], i_rx_byte};
`ifdef UART_COMM_CRC_EN
        // Running the CRC over the received CRC bytes too leaves a zero residue when intact
        r_rx_crc <= crc16_step(r_rx_crc, i_rx_byte);
`endif
      end
    end
  end

  // ---------------------------------------------------------- DISPATCH
`ifdef UART_COMM_CRC_EN
  assign w_crc_ok = (r_rx_crc == 16'h0000);
`else
  assign w_crc_ok = 1'b1;
`endif
  assign w_dispatch = (r_rx_state == RX_DISPATCH);
  assign w_pkt_ok   = !r_len_bad && !r_hdr_bad && w_crc_ok;
  assign w_is_ping  = w_pkt_ok && (r_rx_type == TYPE_PING) && (r_rx_len == 8'(MIN_LEN));
  assign w_is_info  = w_pkt_ok && (r_rx_type == TYPE_INFO) && (r_rx_len == 8'(MIN_LEN));
  assign w_is_job   = w_pkt_ok && (r_rx_type == TYPE_JOB)  && (r_rx_len == 8'(JOB_LEN));

  always_comb begin
    w_reply_type = TYPE_INVALID;
    if (w_is_ping)      w_reply_type = TYPE_PONG;
    else if (w_is_info) w_reply_type = TYPE_INFO;
    else if (w_is_job)  w_reply_type = TYPE_ACK;
  end

  // One increment per event: framing error, timeout, invalid packet or lost reply
  assign w_drop_inc = w_rx_err || w_timeout ||
                      (w_dispatch && (!(w_is_ping || w_is_info || w_is_job) || r_reply_pend));

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_reply_pend <= 1'b0;
      r_reply_type <= '0;
      r_work_data  <= '0;
      r_work_valid <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_work_valid <= 1'b0;
      if (w_load_reply) r_reply_pend <= 1'b0;
      if (w_dispatch) begin
        if (w_is_job) begin
          r_work_data  <= r_payload;
          r_work_valid <= 1'b1;
        end
        if (!r_reply_pend) begin
          r_reply_pend <= 1'b1;
          r_reply_type <= w_reply_type;
        end
      end
      if (w_drop_inc && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------- FIFO
  assign w_fifo_cnt   = r_wr_ptr - r_rd_ptr;
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (w_fifo_cnt == DEPTH_V);
  assign w_fifo_head  = r_fifo[r_rd_ptr[AW-1:0]];
  // A push into a full FIFO succeeds when the head is popped in the same cycle
  assign w_push       = i_nonce_push && (!w_fifo_full || w_pop);

  always_ff @(posedge i_sys_clk) begin
    if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= i_nonce_in;
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ----------------------------------------------------------------- TX
  assign w_info_al    = PW'(SYS_INFO) << (PW - 64);
  assign w_nonce_al   = PW'(w_fifo_head) << (PW - NB);
  assign w_tx_load    = (r_tx_state == TX_IDLE) && (r_reply_pend || !w_fifo_empty);
  assign w_load_reply = w_tx_load && r_reply_pend;
  // Never strobe on back-to-back cycles so the UART has a cycle to raise busy
  assign w_tx_fire    = (r_tx_state == TX_SEND) && !i_tx_busy && !r_tx_start;
  assign w_tx_last    = (r_tx_idx == (r_tx_len - 8'd1));
  assign w_tx_data    = (r_tx_idx >= 8'd4) && (r_tx_idx < (r_tx_len - 8'(CRC_BYTES)));
  // The nonce leaves the FIFO only once its packet is fully issued
  assign w_pop        = w_tx_fire && w_tx_last && r_tx_is_nonce;

  always_comb begin
    w_tx_cur = 8'h00;
    if (r_tx_idx == 8'd0)      w_tx_cur = r_tx_len;
    else if (r_tx_idx == 8'd3) w_tx_cur = r_tx_type;
    else if (w_tx_data)        w_tx_cur = r_tx_payload[PW-1 -: 8];
`ifdef UART_COMM_CRC_EN
    if (r_tx_idx == (r_tx_len - 8'd2))      w_tx_cur = r_tx_crc[15:8];
    else if (r_tx_idx == (r_tx_len - 8'd1)) w_tx_cur = r_tx_crc[7:0];
`endif
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_tx_state <= TX_IDLE;
    else            r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (w_tx_load) w_tx_next = TX_SEND;
      TX_SEND: if (w_tx_fire && w_tx_last) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_len      <= '0;
      r_tx_type     <= '0;
      r_tx_idx      <= '0;
      r_tx_byte     <= '0;
      r_tx_start    <= 1'b0;
      r_tx_is_nonce <= 1'b0;
      r_tx_payload  <= '0;
`ifdef UART_COMM_CRC_EN
      r_tx_crc      <= 16'hFFFF;
`endif
    end else begin
      r_tx_start <= w_tx_fire;
      if (w_tx_load) begin
        r_tx_idx <= '0;
        if (r_reply_pend) begin
          r_tx_type     <= r_reply_type;
          r_tx_len      <= (r_reply_type == TYPE_INFO) ? 8'(INFO_LEN) : 8'(MIN_LEN);
          r_tx_payload  <= w_info_al;
          r_tx_is_nonce <= 1'b0;
        end else begin
          r_tx_type     <= TYPE_NONCE;
          r_tx_len      <= 8'(NONCE_LEN);
          r_tx_payload  <= w_nonce_al;
          r_tx_is_nonce <= 1'b1;
        end
`ifdef UART_COMM_CRC_EN
        r_tx_crc <= 16'hFFFF;
`endif
      end else if (w_tx_fire) begin
        r_tx_byte <= w_tx_cur;
        r_tx_idx  <= r_tx_idx + 8'd1;
        if (w_tx_data) r_tx_payload <= r_tx_payload << 8;
`ifdef UART_COMM_CRC_EN
        if (r_tx_idx < (r_tx_len - 8'd2)) r_tx_crc <= crc16_step(r_tx_crc, w_tx_cur);
`endif
      end
    end
  end

  assign o_tx_start    = r_tx_start;
  assign o_tx_byte     = r_tx_byte;
  assign o_work_data   = r_work_data;
  assign o_work_valid  = r_work_valid;
  assign o_nonce_full  = w_fifo_full;
  assign o_rx_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_comm_engine.sv
// tb/tb_uart_comm_engine.sv - self-checking bench for uart_comm_engine (default build)
module tb_uart_comm_engine;

  localparam int RX_TO = 200;

  logic        clk;
  logic        i_reset_n;
  logic        i_rx_valid;
  logic [7:0]  i_rx_byte;
  logic        i_rx_error;
  logic        o_tx_start;
  logic [7:0]  o_tx_byte;
  logic        i_tx_busy;
  logic [95:0] o_work_data;
  logic        o_work_valid;
  logic [31:0] i_nonce_in;
  logic        i_nonce_push;
  logic        o_nonce_full;
  logic [7:0]  o_rx_drop_cnt;

  logic busy_model;
  logic busy_hold;
  assign i_tx_busy = busy_model | busy_hold;

  uart_comm_engine #(
    .WORK_BYTES (12),
    .NONCE_BYTES(4),
    .NONCE_DEPTH(4),
    .RX_TIMEOUT (RX_TO),
    .SYS_INFO   (64'hDEADBEEF13370D13)
  ) dut (
    .i_sys_clk    (clk),
    .i_reset_n    (i_reset_n),
    .i_rx_valid   (i_rx_valid),
    .i_rx_byte    (i_rx_byte),
    .i_rx_error   (i_rx_error),
    .o_tx_start   (o_tx_start),
    .o_tx_byte    (o_tx_byte),
    .i_tx_busy    (i_tx_busy),
    .o_work_data  (o_work_data),
    .o_work_valid (o_work_valid),
    .i_nonce_in   (i_nonce_in),
    .i_nonce_push (i_nonce_push),
    .o_nonce_full (o_nonce_full),
    .o_rx_drop_cnt(o_rx_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int wv_cnt   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int           n_rx;
    logic [159:0] rx;
    int           n_tx;
    logic [95:0]  tx;
    int           drop_inc;
    bit           job;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input int nrx, input logic [159:0] rx, input int ntx,
                              input logic [95:0] tx, input int d, input bit j);
    vec_t v;
    v.n_rx = nrx; v.rx = rx; v.n_tx = ntx; v.tx = tx; v.drop_inc = d; v.job = j;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(negedge clk);
    i_rx_valid = 1'b1; i_rx_byte = b; i_rx_error = err;
    @(negedge clk);
    i_rx_valid = 1'b0; i_rx_error = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_pkt4(input logic [31:0] p);
    for (int i = 0; i < 4; i++) exp_q.push_back(p[31-8*i -: 8]);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 5000)) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  // Transmit monitor / UART model: every strobe pops the scoreboard, then busy for 3 cycles
  initial begin
    busy_model = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%02h expected=no_byte", o_tx_byte);
        end else begin
          check("tx_byte", o_tx_byte, exp_q.pop_front());
        end
        busy_model = 1'b1;
        repeat (3) @(negedge clk);
        busy_model = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (o_work_valid) wv_cnt++;
    end
  end

  initial begin
    int          exp_drop;
    logic [95:0] exp_work;
    logic [31:0] nonces[5];
    int          n;

    exp_drop = 0;
    exp_work = '0;
    nonces[0] = 32'h11111111; nonces[1] = 32'h22222222; nonces[2] = 32'h33333333;
    nonces[3] = 32'h44444444; nonces[4] = 32'h55555555;

    vecs[0] = mk(4,  {32'h04000002, 128'h0}, 4, {32'h04000003, 64'h0}, 0, 0);
    vecs[1] = mk(4,  {32'h04000000, 128'h0}, 12, 96'h0C000000_DEADBEEF_13370D13, 0, 0);
    vecs[2] = mk(16, {128'h10000004_0102030405060708090A0B0C, 32'h0}, 4, {32'h04000005, 64'h0}, 0, 1);
    vecs[3] = mk(4,  {32'h04000007, 128'h0}, 4, {32'h04000001, 64'h0}, 1, 0);
    vecs[4] = mk(1,  {8'h02, 152'h0}, 4, {32'h04000001, 64'h0}, 1, 0);
    vecs[5] = mk(17, {32'h11000004, {13{8'hAA}}, 24'h0}, 4, {32'h04000001, 64'h0}, 1, 0);
    vecs[6] = mk(5,  {40'h0500000277, 120'h0}, 4, {32'h04000001, 64'h0}, 1, 0);
    vecs[7] = mk(4,  {32'h04000102, 128'h0}, 4, {32'h04000001, 64'h0}, 1, 0);
    vecs[8] = mk(16, {128'h10000004_F0F1F2F3F4F5F6F7F8F9FAFB, 32'h0}, 4, {32'h04000005, 64'h0}, 0, 1);

    i_reset_n = 1'b0; i_rx_valid = 1'b0; i_rx_byte = '0; i_rx_error = 1'b0;
    i_nonce_in = '0; i_nonce_push = 1'b0; busy_hold = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_byte", o_tx_byte, 0);
    check("rst_work_data", o_work_data, 0);
    check("rst_work_valid", o_work_valid, 0);
    check("rst_nonce_full", o_nonce_full, 0);
    check("rst_drop_cnt", o_rx_drop_cnt, 0);
    i_reset_n = 1'b1;
    @(negedge clk);

    // Table-driven packets
    for (int k = 0; k < 9; k++) begin
      vec_t v;
      int   wv0;
      v = vecs[k];
      wv0 = wv_cnt;
      for (int i = 0; i < v.n_tx; i++) exp_q.push_back(v.tx[95-8*i -: 8]);
      for (int i = 0; i < v.n_rx; i++) send_byte(v.rx[159-8*i -: 8], 1'b0);
      wait_drain($sformatf("vec%0d_drain", k));
      exp_drop += v.drop_inc;
      if (v.job) exp_work = v.rx[127 -: 96];
      check($sformatf("vec%0d_drop_cnt", k), o_rx_drop_cnt, exp_drop);
      check($sformatf("vec%0d_work_valid_pulses", k), wv_cnt - wv0, v.job ? 1 : 0);
      check($sformatf("vec%0d_work_data", k), o_work_data, exp_work);
    end

    // Framing error mid-header: aborted silently, counted
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    exp_drop++;
    check("rxerr_drop_cnt", o_rx_drop_cnt, exp_drop);
    push_pkt4(32'h04000003);
    for (int i = 0; i < 4; i++) send_byte(vecs[0].rx[159-8*i -: 8], 1'b0);
    wait_drain("rxerr_ping_drain");

    // Inter-byte timeout on a partial packet: no reply, counted, next PING fine
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (RX_TO + 10) @(negedge clk);
    exp_drop++;
    check("timeout_drop_cnt", o_rx_drop_cnt, exp_drop);
    push_pkt4(32'h04000003);
    for (int i = 0; i < 4; i++) send_byte(vecs[0].rx[159-8*i -: 8], 1'b0);
    wait_drain("timeout_ping_drain");
    check("timeout_drop_after_ping", o_rx_drop_cnt, exp_drop);

    // Reply slot: first PING goes to TX, second waits in the slot, third is lost
    busy_hold = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) send_byte(vecs[0].rx[159-8*i -: 8], 1'b0);
    exp_drop++;
    check("slot_drop_cnt", o_rx_drop_cnt, exp_drop);
    push_pkt4(32'h04000003);
    push_pkt4(32'h04000003);
    busy_hold = 1'b0;
    wait_drain("slot_drain");

    // Nonce FIFO: fill with TX stalled, fifth push dropped, four packets in order
    busy_hold = 1'b1;
    for (int j = 0; j < 5; j++) begin
      i_nonce_in = nonces[j];
      i_nonce_push = 1'b1;
      @(negedge clk);
      if (j == 2) check("fifo_not_full_at_3", o_nonce_full, 0);
      if (j == 3) check("fifo_full_at_4", o_nonce_full, 1);
    end
    i_nonce_push = 1'b0;
    check("fifo_full_after_5", o_nonce_full, 1);
    for (int j = 0; j < 4; j++) begin
      push_pkt4(32'h08000006);
      push_pkt4(nonces[j]);
    end
    busy_hold = 1'b0;
    wait_drain("nonce_drain");
    check("fifo_not_full_end", o_nonce_full, 0);
    check("nonce_drop_cnt_unchanged", o_rx_drop_cnt, exp_drop);

    // Reset in the middle of an INFO reply with nonces waiting behind it
    for (int i = 0; i < 12; i++) exp_q.push_back(vecs[1].tx[95-8*i -: 8]);
    for (int i = 0; i < 4; i++) send_byte(vecs[1].rx[159-8*i -: 8], 1'b0);
    n = 0;
    while ((exp_q.size() > 8) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check("info_partial_reached", (exp_q.size() <= 8) ? 1 : 0, 1);
    for (int j = 0; j < 2; j++) begin
      i_nonce_in = nonces[j];
      i_nonce_push = 1'b1;
      @(negedge clk);
    end
    i_nonce_push = 1'b0;
    @(negedge clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("midrst_tx_start", o_tx_start, 0);
    exp_q.delete();
    @(negedge clk);
    check("midrst_tx_byte", o_tx_byte, 0);
    check("midrst_drop_cnt", o_rx_drop_cnt, 0);
    check("midrst_work_data", o_work_data, 0);
    check("midrst_nonce_full", o_nonce_full, 0);
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check("midrst_no_tx_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
